// File: rtl/apb_front_arbiter.sv
// apb_front_arbiter
// Round-robin arbiter that shares one APB requester front interface among
// NUM_REQ local masters. One transaction is outstanding at a time; the winner
// alone receives the read data and the completion pulse.
// Optional feature: define APB_ARB_TIMEOUT_EN to add an access timeout that
// answers the master with rsp_err and then drains the late completion.
module apb_front_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TO_CYCLES  = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          m_transfer,
  output logic                          m_write,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_ready
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    SETUP_WAIT  = 3'd2,
    ACCESS_WAIT = 3'd3
`ifdef APB_ARB_TIMEOUT_EN
    , DRAIN     = 3'd4
`endif
  } state_t;

  state_t state, state_next;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W:0]   scan_idx;
  logic             grant_found;
  logic             grant;
  logic             access_done;
  logic             cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            access_timeout;
  logic            rsp_err_q;
`endif

  // Find the first pending master at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Grants happen only from IDLE, and never while reset is held.
  always_comb begin
    grant     = (state == IDLE) && grant_found && !PRESET;
    req_ready = '0;
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign access_done = (state == ACCESS_WAIT) && m_ready;
  assign m_transfer  = (state == ISSUE);
  assign m_write     = cap_write;
  assign m_addr      = cap_addr;
  assign m_wdata     = cap_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  assign access_timeout = (state == ACCESS_WAIT) && !m_ready &&
                          (to_cnt == TO_W'(TO_CYCLES - 1));
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; m_ready is deliberately ignored in SETUP_WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (grant) state_next = ISSUE;
      ISSUE:       state_next = SETUP_WAIT;
      SETUP_WAIT:  state_next = ACCESS_WAIT;
      ACCESS_WAIT: begin
        if (m_ready) begin
          state_next = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (access_timeout) begin
          state_next = DRAIN;
        end
`endif
      end
`ifdef APB_ARB_TIMEOUT_EN
      DRAIN:       if (m_ready) state_next = IDLE;
`endif
      default:     state_next = IDLE;
    endcase
  end

  // Capture the winning request, advance the pointer and register responses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rr_ptr    <= '0;
      owner_idx <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (grant) begin
        cap_write <= req_write[grant_idx];
        cap_addr  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cap_wdata <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        owner_idx <= grant_idx;
        rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
      end
      if (access_done) begin
        rsp_valid[owner_idx] <= 1'b1;
        rsp_rdata            <= m_rdata;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (access_timeout) begin
        rsp_valid[owner_idx] <= 1'b1;
        rsp_rdata            <= '0;
      end
`endif
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  // Timeout counter: cleared before ACCESS_WAIT, counts not-ready access cycles.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= access_timeout;
      if (state == SETUP_WAIT) begin
        to_cnt <= '0;
      end else if ((state == ACCESS_WAIT) && !m_ready) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_front_arbiter.sv
// tb_apb_front_arbiter
// Directed bench for apb_front_arbiter with hand-computed expectations.
// Scenario T6 is compiled only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_front_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            m_transfer;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_ready;

  int checks = 0;
  int errors = 0;
  int g;
  int p;
  logic [N-1:0] exp_onehot;

  apb_front_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_transfer(m_transfer), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  // Free-running clock.
  always #5 PCLK = ~PCLK;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wdata;
    req_valid[idx]          = 1'b1;
  endtask

  task automatic releaseReq(input int idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic doReset();
    PRESET    = 1'b1;
    req_valid = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    tick();
    tick();
    PRESET = 1'b0;
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_rdata   = '0;
    m_ready   = 1'b0;
    tick();
    tick();
    settle();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_m_transfer", m_transfer, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_wdata", m_wdata, 0);
    PRESET = 1'b0;

    // T1: single read from master 1, zero-wait slave
    tick();
    applyStimulus(1, 1'b0, 32'h1000_1004, 32'h0);
    settle();
    checkOutput("t1_grant", req_ready, 4'b0010);
    tick();
    releaseReq(1);
    settle();
    checkOutput("t1_transfer", m_transfer, 1);
    checkOutput("t1_addr", m_addr, 32'h1000_1004);
    checkOutput("t1_write", m_write, 0);
    checkOutput("t1_ready_drop", req_ready, 0);
    tick();
    m_ready = 1'b1;
    m_rdata = 32'hCAFE_0001;
    settle();
    checkOutput("t1_setup_transfer", m_transfer, 0);
    checkOutput("t1_c2_rsp", rsp_valid, 0);
    tick();
    settle();
    checkOutput("t1_c3_rsp", rsp_valid, 0);
    tick();
    settle();
    checkOutput("t1_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("t1_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    checkOutput("t1_rsp_err", rsp_err, 0);
    m_ready = 1'b0;
    tick();
    settle();
    checkOutput("t1_rsp_pulse", rsp_valid, 0);

    // T2: all masters pending continuously, zero-wait slave
    doReset();
    for (int i = 0; i < N; i++) begin
      applyStimulus(i, 1'b0, 32'h2000_0000 + 32'(i * 16), 32'h0);
    end
    m_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      g = t % N;
      p = (t + N - 1) % N;
      settle();
      exp_onehot = 4'b0001 << g;
      checkOutput($sformatf("t2_grant%0d", t), req_ready, exp_onehot);
      checkOutput($sformatf("t2_idle_xfer%0d", t), m_transfer, 0);
      if (t > 0) begin
        exp_onehot = 4'b0001 << p;
        checkOutput($sformatf("t2_rsp_valid%0d", t), rsp_valid, exp_onehot);
        checkOutput($sformatf("t2_rsp_rdata%0d", t), rsp_rdata, 32'hD000_0000 + 32'(p));
      end
      tick();
      settle();
      checkOutput($sformatf("t2_transfer%0d", t), m_transfer, 1);
      checkOutput($sformatf("t2_addr%0d", t), m_addr, 32'h2000_0000 + 32'(g * 16));
      m_rdata = 32'hD000_0000 + 32'(g);
      tick();
      tick();
      tick();
    end
    settle();
    checkOutput("t2_last_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("t2_last_rsp_rdata", rsp_rdata, 32'hD000_0001);

    // T3: write with three wait states and PREADY high during setup
    doReset();
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'hA5A5_A5A5);
    settle();
    checkOutput("t3_grant", req_ready, 4'b0001);
    tick();
    releaseReq(0);
    settle();
    checkOutput("t3_transfer", m_transfer, 1);
    checkOutput("t3_write", m_write, 1);
    checkOutput("t3_addr", m_addr, 32'h1000_0010);
    checkOutput("t3_wdata", m_wdata, 32'hA5A5_A5A5);
    tick();
    m_ready = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    settle();
    checkOutput("t3_c2_rsp", rsp_valid, 0);
    tick();
    m_ready = 1'b0;
    settle();
    checkOutput("t3_c3_rsp", rsp_valid, 0);
    for (int c = 4; c <= 6; c++) begin
      tick();
      if (c == 6) m_ready = 1'b1;
      settle();
      checkOutput($sformatf("t3_c%0d_rsp", c), rsp_valid, 0);
      checkOutput($sformatf("t3_c%0d_addr", c), m_addr, 32'h1000_0010);
      checkOutput($sformatf("t3_c%0d_wdata", c), m_wdata, 32'hA5A5_A5A5);
    end
    tick();
    m_ready = 1'b0;
    settle();
    checkOutput("t3_rsp_valid", rsp_valid, 4'b0001);
    checkOutput("t3_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
    checkOutput("t3_addr_held", m_addr, 32'h1000_0010);

    // T4: master 3 then master 1, pointer wraps to 0
    doReset();
    applyStimulus(3, 1'b0, 32'h3000_000C, 32'h0);
    settle();
    checkOutput("t4_grant3", req_ready, 4'b1000);
    tick();
    releaseReq(3);
    applyStimulus(1, 1'b0, 32'h3000_0004, 32'h0);
    m_ready = 1'b1;
    m_rdata = 32'h3333_0003;
    settle();
    checkOutput("t4_addr3", m_addr, 32'h3000_000C);
    checkOutput("t4_busy_ready", req_ready, 0);
    tick();
    tick();
    tick();
    settle();
    checkOutput("t4_rsp3", rsp_valid, 4'b1000);
    checkOutput("t4_rdata3", rsp_rdata, 32'h3333_0003);
    checkOutput("t4_grant1", req_ready, 4'b0010);
    m_rdata = 32'h1111_0001;
    tick();
    releaseReq(1);
    settle();
    checkOutput("t4_transfer1", m_transfer, 1);
    checkOutput("t4_addr1", m_addr, 32'h3000_0004);
    tick();
    tick();
    tick();
    settle();
    checkOutput("t4_rsp1", rsp_valid, 4'b0010);
    checkOutput("t4_rdata1", rsp_rdata, 32'h1111_0001);
    m_ready = 1'b0;

    // T5: reset in ACCESS_WAIT discards the transfer; pointer restarts at 0
    doReset();
    applyStimulus(2, 1'b0, 32'h5000_0008, 32'h0);
    settle();
    checkOutput("t5_grant2", req_ready, 4'b0100);
    tick();
    releaseReq(2);
    applyStimulus(1, 1'b0, 32'h5000_0004, 32'h0);
    applyStimulus(3, 1'b0, 32'h5000_000C, 32'h0);
    settle();
    checkOutput("t5_transfer2", m_transfer, 1);
    tick();
    tick();
    settle();
    checkOutput("t5_addr2", m_addr, 32'h5000_0008);
    PRESET = 1'b1;
    settle();
    checkOutput("t5_rst_transfer", m_transfer, 0);
    checkOutput("t5_rst_addr", m_addr, 0);
    checkOutput("t5_rst_wdata", m_wdata, 0);
    checkOutput("t5_rst_write", m_write, 0);
    checkOutput("t5_rst_ready", req_ready, 0);
    checkOutput("t5_rst_rsp", rsp_valid, 0);
    tick();
    tick();
    PRESET = 1'b0;
    settle();
    checkOutput("t5_regrant", req_ready, 4'b0010);
    checkOutput("t5_no_rsp", rsp_valid, 0);
    m_ready = 1'b1;
    m_rdata = 32'h5555_0001;
    tick();
    releaseReq(1);
    settle();
    checkOutput("t5_transfer1", m_transfer, 1);
    checkOutput("t5_addr1", m_addr, 32'h5000_0004);
    tick();
    tick();
    tick();
    settle();
    checkOutput("t5_rsp1", rsp_valid, 4'b0010);
    checkOutput("t5_rdata1", rsp_rdata, 32'h5555_0001);
    checkOutput("t5_grant3", req_ready, 4'b1000);

`ifdef APB_ARB_TIMEOUT_EN
    // T6: slave never answers; timeout response, then drain
    doReset();
    applyStimulus(0, 1'b0, 32'h6000_0000, 32'h0);
    settle();
    checkOutput("t6_grant0", req_ready, 4'b0001);
    tick();
    releaseReq(0);
    applyStimulus(1, 1'b0, 32'h6000_0004, 32'h0);
    settle();
    for (int c = 2; c <= 18; c++) begin
      tick();
      settle();
      checkOutput($sformatf("t6_c%0d_rsp", c), rsp_valid, 0);
      checkOutput($sformatf("t6_c%0d_ready", c), req_ready, 0);
    end
    tick();
    settle();
    checkOutput("t6_to_valid", rsp_valid, 4'b0001);
    checkOutput("t6_to_err", rsp_err, 1);
    checkOutput("t6_to_rdata", rsp_rdata, 0);
    checkOutput("t6_to_ready", req_ready, 0);
    for (int c = 20; c <= 23; c++) begin
      tick();
      settle();
      checkOutput($sformatf("t6_drain%0d_ready", c), req_ready, 0);
      checkOutput($sformatf("t6_drain%0d_xfer", c), m_transfer, 0);
      checkOutput($sformatf("t6_drain%0d_rsp", c), rsp_valid, 0);
    end
    tick();
    m_ready = 1'b1;
    m_rdata = 32'h6666_6666;
    settle();
    checkOutput("t6_drain_ready", req_ready, 0);
    tick();
    m_ready = 1'b0;
    settle();
    checkOutput("t6_regrant", req_ready, 4'b0010);
    checkOutput("t6_no_second_rsp", rsp_valid, 0);
    checkOutput("t6_err_clear", rsp_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
